reg_writeback_arbiter: RTL and testbench
========================================

Name: reg_writeback_arbiter

Overview:
- Per-thread controller that owns the single write port of a thread's register file.
- Arbitrates writebacks from three requesters (ALU result, LSU load return, decoded constant) with round-robin fairness.
- Keeps a load scoreboard so the core scheduler can stall instructions that depend on outstanding loads.
- Sits between the thread's ALU/LSU/decoder outputs and the register file write inputs; one instance per thread.

Parameters:
- DATA_BITS, 8, width of write data.
- NUM_REGS, 16, registers per thread; address width is 4.
- WRITABLE_REGS, 13, R0..R12 are writable; R13..R15 (%blockIdx, %blockDim, %threadIdx) are read-only.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  thread active; when low, no grants and no scoreboard updates.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_rd  in  4  ALU destination register.
- alu_data  in  DATA_BITS  ALU result.
- lsu_valid, lsu_ready, lsu_rd, lsu_data  (in, out, in, in)  (1, 1, 4, DATA_BITS)  same handshake, for LSU load return.
- imm_valid, imm_ready, imm_rd, imm_data  (in, out, in, in)  (1, 1, 4, DATA_BITS)  same handshake, for CONST immediate.
- issue_valid  in  1  scheduler issues an instruction this cycle.
- issue_is_load  in  1  the issued instruction is LDR.
- issue_rd  in  4  destination of the issued instruction.
- query_rs, query_rt, query_rd  in  4 each  operands of the candidate instruction.
- hazard  out  1  combinational: candidate touches a register with a pending load.
- rf_we  out  1  registered write strobe to the register file.
- rf_waddr  out  4  registered write address.
- rf_wdata  out  DATA_BITS  registered write data.
- pending_mask  out  NUM_REGS  registered scoreboard bits.
- illegal_write  out  1  registered one-cycle pulse: an accepted write targeted R13..R15.

Behaviour:
- Reset (reset low, asynchronous): rr pointer = ALU; pending_mask = 0; rf_we = 0; rf_waddr = 0; rf_wdata = 0; illegal_write = 0. All ready outputs are 0 while in reset.
- Arbitration state machine: 2-bit rr pointer with states PRI_ALU, PRI_LSU, PRI_IMM (encoding 3 unused; it recovers to PRI_ALU).
- Search order starts at the pointer: ALU→LSU→IMM, LSU→IMM→ALU, or IMM→ALU→LSU.
- The first valid requester in search order is granted. Its ready is combinational and high for that cycle only; at most one ready is high per cycle.
- Accept = valid && ready. On accept, the pointer moves to the source after the granted one. With no accept, the pointer holds.
- Requesters hold valid/rd/data stable until accepted. A valid may drop without penalty.
- Latency: an accept in cycle N produces rf_we = 1 with rf_waddr/rf_wdata in cycle N+1, for exactly one cycle unless another accept follows. Back-to-back accepts give one write per cycle.
- Accepted rd >= WRITABLE_REGS: rf_we stays 0 in N+1, illegal_write = 1 in N+1, the handshake still completes, and the pointer still advances.
- Scoreboard:
  - issue_valid && issue_is_load && issue_rd < WRITABLE_REGS sets pending[issue_rd] on the next edge.
  - An LSU accept clears pending[lsu_rd] on the next edge.
  - Set and clear of the same register in one cycle: set wins (a new load is outstanding).
  - Bits 13..15 are never set.
- hazard = enable && (pending[query_rs] | pending[query_rt] | pending[query_rd]). It is purely combinational from the registered mask.
- The scheduler must not issue while hazard = 1. If it does, the block still updates the scoreboard as specified; there is no extra protection.
- enable low: all readies 0, rf_we deasserts on the next edge, pointer and pending_mask hold (a pending load survives a disable and clears on LSU return after re-enable).
- Reset asserted mid-transfer: the in-flight write is lost and rf_we is 0 immediately. Requesters re-present after reset.

Decomposition:
- Shared package gets: the writeback source enum (WB_ALU=0, WB_LSU=1, WB_IMM=2), reused by the decoder's reg_input_mux; and the constants NUM_REGS, WRITABLE_REGS, and the read-only indices 13/14/15.
- One natural sub-module: rr_arbiter3 (3-way round-robin grant with pointer). The scoreboard stays inline.

Test Plan:
- Reset, then alu_valid=1, rd=3, data=0x2A → alu_ready=1 in the same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x2A; the cycle after, rf_we=0.
- All three valid every cycle (rd 1/2/3) → grants ALU, LSU, IMM, ALU…; rf_waddr sequence 1,2,3,1 with rf_we continuously high.
- Issue LDR rd=5 → pending_mask=0x0020; query_rs=5 gives hazard=1; LSU accept with rd=5 → mask returns to 0, hazard=0.
- Same cycle: issue LDR rd=7 and LSU accept rd=7 → pending[7] remains 1.
- IMM write to rd=14 → imm_ready=1; next cycle rf_we=0, illegal_write=1; issue LDR rd=13 → mask unchanged.
- enable=0 with alu_valid=1 → alu_ready=0 and no rf_we; pending[4] held. Assert reset mid-stream → rf_we and pending_mask go to 0 asynchronously.

Source files
------------

// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared types and constants for the per-thread register-file writeback path.
// The writeback source enum is also used by the decoder's reg_input_mux.
package reg_writeback_arbiter_pkg;

    localparam int NUM_REGS      = 16;
    localparam int WRITABLE_REGS = 13;

    localparam logic [3:0] REG_BLOCK_IDX  = 4'(WRITABLE_REGS);
    localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
    localparam logic [3:0] REG_THREAD_IDX = 4'd15;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_IMM = 2'd2
    } wb_src_e;

    typedef enum logic [1:0] {
        PRI_ALU = 2'd0,
        PRI_LSU = 2'd1,
        PRI_IMM = 2'd2
    } rr_state_e;

    function automatic logic is_read_only(input logic [3:0] rd);
        return (rd == REG_BLOCK_IDX) || (rd == REG_BLOCK_DIM) || (rd == REG_THREAD_IDX);
    endfunction

endpackage

// File: rtl/reg_writeback_arbiter_rr_arbiter3.sv
// Three-way round-robin grant (bit 0 = ALU, 1 = LSU, 2 = IMM) with a registered
// priority pointer; a grant is an accept, so the pointer moves past the winner.
module rr_arbiter3
    import reg_writeback_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    rr_state_e ptr_q;
    rr_state_e ptr_d;
    logic      en_s;

    // Grants are suppressed while disabled or held in reset.
    assign en_s = enable & reset;

    // Search order starts at the pointer; the unused encoding behaves like PRI_ALU.
    always_comb begin
        gnt = 3'b000;
        if (!en_s) begin
            gnt = 3'b000;
        end else begin
            case (ptr_q)
                PRI_LSU: begin
                    if (req[1])      gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else             gnt = 3'b000;
                end
                PRI_IMM: begin
                    if (req[2])      gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else             gnt = 3'b000;
                end
                default: begin
                    if (req[0])      gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else             gnt = 3'b000;
                end
            endcase
        end
    end

    // Next pointer: the source after the winner, otherwise hold (illegal state recovers).
    always_comb begin
        ptr_d = ptr_q;
        case (gnt)
            3'b001:  ptr_d = PRI_LSU;
            3'b010:  ptr_d = PRI_IMM;
            3'b100:  ptr_d = PRI_ALU;
            default: begin
                case (ptr_q)
                    PRI_ALU, PRI_LSU, PRI_IMM: ptr_d = ptr_q;
                    default:                   ptr_d = PRI_ALU;
                endcase
            end
        endcase
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= PRI_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Owns a thread's register-file write port: round-robin writeback arbitration
// between ALU, LSU and CONST sources, plus the outstanding-load scoreboard.
module reg_writeback_arbiter
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [3:0]           alu_rd,
    input  logic [DATA_BITS-1:0] alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [3:0]           lsu_rd,
    input  logic [DATA_BITS-1:0] lsu_data,
    input  logic                 imm_valid,
    output logic                 imm_ready,
    input  logic [3:0]           imm_rd,
    input  logic [DATA_BITS-1:0] imm_data,
    input  logic                 issue_valid,
    input  logic                 issue_is_load,
    input  logic [3:0]           issue_rd,
    input  logic [3:0]           query_rs,
    input  logic [3:0]           query_rt,
    input  logic [3:0]           query_rd,
    output logic                 hazard,
    output logic                 rf_we,
    output logic [3:0]           rf_waddr,
    output logic [DATA_BITS-1:0] rf_wdata,
    output logic [NUM_REGS-1:0]  pending_mask,
    output logic                 illegal_write
);

    localparam logic [NUM_REGS-1:0] BIT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [2:0]           gnt_s;
    logic                 acc_s;
    wb_src_e              src_s;
    logic [3:0]           acc_rd_s;
    logic [DATA_BITS-1:0] acc_data_s;
    logic [NUM_REGS-1:0]  set_s;
    logic [NUM_REGS-1:0]  clr_s;

    logic                 rf_we_d, rf_we_q;
    logic [3:0]           rf_waddr_d, rf_waddr_q;
    logic [DATA_BITS-1:0] rf_wdata_d, rf_wdata_q;
    logic [NUM_REGS-1:0]  pending_d, pending_q;
    logic                 illegal_write_d, illegal_write_q;

    rr_arbiter3 u_rr (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .req    ({imm_valid, lsu_valid, alu_valid}),
        .gnt    (gnt_s)
    );

    assign alu_ready = gnt_s[0];
    assign lsu_ready = gnt_s[1];
    assign imm_ready = gnt_s[2];

    // Decode the one-hot grant into the accepted source.
    always_comb begin
        acc_s = 1'b0;
        src_s = WB_ALU;
        case (gnt_s)
            3'b001:  begin acc_s = 1'b1; src_s = WB_ALU; end
            3'b010:  begin acc_s = 1'b1; src_s = WB_LSU; end
            3'b100:  begin acc_s = 1'b1; src_s = WB_IMM; end
            default: begin acc_s = 1'b0; src_s = WB_ALU; end
        endcase
    end

    // Writeback operand mux.
    always_comb begin
        acc_rd_s   = alu_rd;
        acc_data_s = alu_data;
        case (src_s)
            WB_LSU:  begin acc_rd_s = lsu_rd; acc_data_s = lsu_data; end
            WB_IMM:  begin acc_rd_s = imm_rd; acc_data_s = imm_data; end
            default: begin acc_rd_s = alu_rd; acc_data_s = alu_data; end
        endcase
    end

    // Next-state for the write port and scoreboard; a set beats a same-cycle clear.
    always_comb begin
        rf_we_d         = acc_s & ~is_read_only(acc_rd_s);
        illegal_write_d = acc_s &  is_read_only(acc_rd_s);
        rf_waddr_d      = rf_we_d ? acc_rd_s   : rf_waddr_q;
        rf_wdata_d      = rf_we_d ? acc_data_s : rf_wdata_q;
        clr_s           = (enable && gnt_s[1]) ? (BIT0 << lsu_rd) : {NUM_REGS{1'b0}};
        set_s           = (enable && issue_valid && issue_is_load && !is_read_only(issue_rd))
                          ? (BIT0 << issue_rd) : {NUM_REGS{1'b0}};
        pending_d       = (pending_q & ~clr_s) | set_s;
    end

    // Output and scoreboard registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q         <= 1'b0;
            rf_waddr_q      <= 4'd0;
            rf_wdata_q      <= {DATA_BITS{1'b0}};
            pending_q       <= {NUM_REGS{1'b0}};
            illegal_write_q <= 1'b0;
        end else begin
            rf_we_q         <= rf_we_d;
            rf_waddr_q      <= rf_waddr_d;
            rf_wdata_q      <= rf_wdata_d;
            pending_q       <= pending_d;
            illegal_write_q <= illegal_write_d;
        end
    end

    assign rf_we         = rf_we_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign pending_mask  = pending_q;
    assign illegal_write = illegal_write_q;
    assign hazard        = enable & (pending_q[query_rs] | pending_q[query_rt] | pending_q[query_rd]);

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Randomized scoreboard bench for reg_writeback_arbiter against a behavioural model.
module tb_reg_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic        alu_valid, lsu_valid, imm_valid;
    logic        alu_ready, lsu_ready, imm_ready;
    logic [3:0]  alu_rd, lsu_rd, imm_rd;
    logic [7:0]  alu_data, lsu_data, imm_data;
    logic        issue_valid, issue_is_load;
    logic [3:0]  issue_rd, query_rs, query_rt, query_rd;
    logic        hazard, rf_we, illegal_write;
    logic [3:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [15:0] pending_mask;

    reg_writeback_arbiter #(.DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .imm_valid(imm_valid), .imm_ready(imm_ready), .imm_rd(imm_rd), .imm_data(imm_data),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
        .query_rs(query_rs), .query_rt(query_rt), .query_rd(query_rd),
        .hazard(hazard), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending_mask(pending_mask), .illegal_write(illegal_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rd;
        logic [7:0] data;
        bit         ill;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    // Reference model: next source to favour (0 ALU, 1 LSU, 2 IMM) and outstanding loads.
    int  ptr = 0;
    bit  pend[16];
    int  last_g = -1;

    bit         hv[3];
    logic [3:0] hrd[3];
    logic [7:0] hd[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pend_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = pend[i];
        return v;
    endfunction

    task automatic idle();
        alu_valid = 1'b0; lsu_valid = 1'b0; imm_valid = 1'b0;
        issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 4'd0;
        query_rs = 4'd0; query_rt = 4'd0; query_rd = 4'd0;
    endtask

    // Called at a falling edge with inputs applied: check combinational outputs,
    // predict the accept, and advance the model to the next falling edge.
    task automatic tick();
        bit [2:0] v;
        bit [2:0] er;
        int       g;
        wb_t      e;
        #1;
        v = {imm_valid, lsu_valid, alu_valid};
        g = -1;
        if (enable && reset) begin
            for (int k = 0; k < 3; k++) begin
                int s = (ptr + k) % 3;
                if (g < 0 && v[s]) g = s;
            end
        end
        er = 3'b000;
        if (g >= 0) er[g] = 1'b1;
        chk("ready", {29'd0, imm_ready, lsu_ready, alu_ready}, {29'd0, er});
        chk("pending_mask", {16'd0, pending_mask}, {16'd0, pend_vec()});
        chk("hazard", {31'd0, hazard},
            {31'd0, enable && (pend[query_rs] || pend[query_rt] || pend[query_rd])});
        if (g >= 0) begin
            case (g)
                0:       begin e.rd = alu_rd; e.data = alu_data; end
                1:       begin e.rd = lsu_rd; e.data = lsu_data; end
                default: begin e.rd = imm_rd; e.data = imm_data; end
            endcase
            e.ill = (e.rd >= 4'd13);
            exp_q.push_back(e);
            ptr = (g + 1) % 3;
        end
        if (enable) begin
            if (g == 1) pend[lsu_rd] = 1'b0;
            if (issue_valid && issue_is_load && issue_rd < 4'd13) pend[issue_rd] = 1'b1;
        end
        last_g = g;
        @(negedge clk);
    endtask

    // Monitor: every write-port event must match the oldest predicted accept.
    always @(negedge clk) begin : monitor
        wb_t e;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", {31'd0, rf_we}, {31'd0, !e.ill});
                chk("illegal_write", {31'd0, illegal_write}, {31'd0, e.ill});
                if (!e.ill) begin
                    chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, e.rd});
                    chk("rf_wdata", {24'd0, rf_wdata}, {24'd0, e.data});
                end
            end else begin
                chk("rf_we_idle", {31'd0, rf_we}, 32'd0);
                chk("illegal_idle", {31'd0, illegal_write}, 32'd0);
            end
        end
    end

    initial begin
        reset = 1'b0;
        enable = 1'b1;
        idle();
        alu_rd = 4'd0; lsu_rd = 4'd0; imm_rd = 4'd0;
        alu_data = 8'd0; lsu_data = 8'd0; imm_data = 8'd0;
        alu_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_waddr", {28'd0, rf_waddr}, 32'd0);
        chk("reset_wdata", {24'd0, rf_wdata}, 32'd0);
        chk("reset_illegal", {31'd0, illegal_write}, 32'd0);
        chk("reset_pending", {16'd0, pending_mask}, 32'd0);
        chk("reset_ready", {29'd0, imm_ready, lsu_ready, alu_ready}, 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;

        // Single ALU write and its one-cycle strobe.
        alu_rd = 4'd3; alu_data = 8'h2A; tick();
        idle(); tick(); tick();

        // Three simultaneous requesters rotate fairly.
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 8'h11;
        lsu_valid = 1'b1; lsu_rd = 4'd2; lsu_data = 8'h22;
        imm_valid = 1'b1; imm_rd = 4'd3; imm_data = 8'h33;
        repeat (4) tick();
        idle(); tick();

        // Load scoreboard set, hazard, clear on LSU return.
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 4'd5; tick();
        idle(); query_rs = 4'd5; tick();
        lsu_valid = 1'b1; lsu_rd = 4'd5; lsu_data = 8'h55; query_rt = 4'd5; tick();
        idle(); query_rs = 4'd5; tick(); tick();

        // Same-cycle set and clear of R7: set wins.
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 4'd7; tick();
        lsu_valid = 1'b1; lsu_rd = 4'd7; lsu_data = 8'h77; tick();
        idle(); query_rd = 4'd7; tick();
        lsu_valid = 1'b1; lsu_rd = 4'd7; lsu_data = 8'h78; tick();
        idle(); tick();

        // Read-only destinations.
        imm_valid = 1'b1; imm_rd = 4'd14; imm_data = 8'hE0; tick();
        idle(); issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 4'd13; tick();
        idle(); tick();

        // Disable holds the pointer and a pending load.
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 4'd4; tick();
        idle(); enable = 1'b0; alu_valid = 1'b1; alu_rd = 4'd8; alu_data = 8'h88;
        query_rs = 4'd4; lsu_valid = 1'b1; lsu_rd = 4'd4; lsu_data = 8'h44;
        repeat (3) tick();
        enable = 1'b1; repeat (2) tick();
        idle(); tick();

        // Randomized traffic with requester hold-until-accept.
        for (int s = 0; s < 3; s++) hv[s] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < 3; s++) begin
                if (!(hv[s] && last_g != s && $urandom_range(9) != 0)) begin
                    hv[s]  = ($urandom_range(1) == 1);
                    hrd[s] = 4'($urandom_range(15));
                    hd[s]  = 8'($urandom);
                end
            end
            alu_valid = hv[0]; alu_rd = hrd[0]; alu_data = hd[0];
            lsu_valid = hv[1]; lsu_rd = hrd[1]; lsu_data = hd[1];
            imm_valid = hv[2]; imm_rd = hrd[2]; imm_data = hd[2];
            enable        = ($urandom_range(9) != 0);
            issue_valid   = ($urandom_range(2) == 0);
            issue_is_load = ($urandom_range(1) == 1);
            issue_rd      = 4'($urandom_range(15));
            query_rs      = 4'($urandom_range(15));
            query_rt      = 4'($urandom_range(15));
            query_rd      = 4'($urandom_range(15));
            tick();
        end
        enable = 1'b1; idle(); tick(); tick();

        // Reset asserted while a write is on the port and a load is pending.
        alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 8'hC3;
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 4'd6; tick();
        #2;
        mon_en = 1'b0;
        chk("pre_reset_rf_we", {31'd0, rf_we}, 32'd1);
        chk("pre_reset_pend6", {31'd0, pending_mask[6]}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rf_we", {31'd0, rf_we}, 32'd0);
        chk("async_pending", {16'd0, pending_mask}, 32'd0);
        chk("async_ready", {29'd0, imm_ready, lsu_ready, alu_ready}, 32'd0);
        exp_q.delete();
        ptr = 0;
        for (int i = 0; i < 16; i++) pend[i] = 1'b0;
        @(negedge clk);
        idle(); reset = 1'b1; mon_en = 1'b1;

        // After reset ALU has priority again.
        alu_valid = 1'b1; alu_rd = 4'd9;  alu_data = 8'h99;
        lsu_valid = 1'b1; lsu_rd = 4'd10; lsu_data = 8'hAA;
        imm_valid = 1'b1; imm_rd = 4'd11; imm_data = 8'hBB;
        tick();
        idle(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
